// File: rtl/pipe_sequencer.sv
// Purpose: control sequencer for a 5-stage pipeline. Runs IDLE -> RUN -> DRAIN -> HALTED and drives the PC and pipeline-register enables/flushes. Optional perf counters are enabled by PIPE_SEQ_PERF_CNT_EN.
// Latency: all enables, flushes and status outputs are combinational from the current state and inputs (zero cycles). State and counters update on the clock edge.
// Backpressure: a load-use hazard stalls PC and IF/ID and injects one bubble into ID/EX. DRAIN freezes fetch for DRAIN_CYCLES cycles before HALTED.
module pipe_sequencer #(
  parameter int unsigned DRAIN_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       halt_id,
  input  logic       jump_id,
  input  logic       branch_taken,
  input  logic       id_ex_mem_rd,
  input  logic [2:0] id_ex_rd,
  input  logic [2:0] if_id_rs,
  input  logic [2:0] if_id_rt,
  input  logic       if_id_uses_rt,
  output logic       pc_wr,
  output logic       if_id_wr,
  output logic       if_id_flush,
  output logic       id_ex_flush,
  output logic       busy,
  output logic       done,
`ifdef PIPE_SEQ_PERF_CNT_EN
  output logic [15:0] stall_cnt,
  output logic [15:0] flush_cnt,
`endif
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    DRAIN  = 2'd2,
    HALTED = 2'd3
  } seqState_t;

  // The drain counter starts one below the cycle count because the counter reaching zero marks the last DRAIN cycle.
  localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CYCLES - 1);

  seqState_t  curState, nextState;
  logic [3:0] drainCnt, drainNext;
  logic       loadUse;

`ifdef PIPE_SEQ_PERF_CNT_EN
  logic       stallEvt, flushEvt;
  logic [15:0] stallCntQ, flushCntQ;
`endif

  // Hazard detection: a load in EX feeds a register read by the instruction in ID.
  assign loadUse = id_ex_mem_rd &
                   ((id_ex_rd == if_id_rs) | (if_id_uses_rt & (id_ex_rd == if_id_rt)));

  // State and drain counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      curState <= IDLE;
      drainCnt <= 4'd0;
    end else begin
      curState <= nextState;
      drainCnt <= drainNext;
    end
  end

  // Next-state and pipeline control decode. Priority in RUN: branch, then load-use, then jump, then halt.
  always_comb begin
    nextState   = curState;
    drainNext   = drainCnt;
    pc_wr       = 1'b0;
    if_id_wr    = 1'b0;
    if_id_flush = 1'b1;
    id_ex_flush = 1'b1;
`ifdef PIPE_SEQ_PERF_CNT_EN
    stallEvt    = 1'b0;
    flushEvt    = 1'b0;
`endif
    case (curState)
      IDLE: begin
        if (start) nextState = RUN;
      end
      RUN: begin
        if (branch_taken) begin
          pc_wr       = 1'b1;
          if_id_wr    = 1'b1;
`ifdef PIPE_SEQ_PERF_CNT_EN
          flushEvt    = 1'b1;
`endif
        end else if (loadUse) begin
          if_id_flush = 1'b0;
`ifdef PIPE_SEQ_PERF_CNT_EN
          stallEvt    = 1'b1;
`endif
        end else if (jump_id) begin
          pc_wr       = 1'b1;
          if_id_wr    = 1'b1;
          id_ex_flush = 1'b0;
`ifdef PIPE_SEQ_PERF_CNT_EN
          flushEvt    = 1'b1;
`endif
        end else if (halt_id) begin
          // The halt itself moves on into EX; only fetch is frozen.
          id_ex_flush = 1'b0;
          drainNext   = DRAIN_LOAD;
          nextState   = DRAIN;
        end else begin
          pc_wr       = 1'b1;
          if_id_wr    = 1'b1;
          if_id_flush = 1'b0;
          id_ex_flush = 1'b0;
        end
      end
      DRAIN: begin
        if (drainCnt == 4'd0) nextState = HALTED;
        else                  drainNext = drainCnt - 4'd1;
      end
      default: ; // HALTED: only reset leaves.
    endcase
  end

  assign busy  = (curState == RUN) || (curState == DRAIN);
  assign done  = (curState == HALTED);
  assign state = curState;

`ifdef PIPE_SEQ_PERF_CNT_EN
  // Saturating event counters for stalls and control-flow flushes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stallCntQ <= 16'd0;
      flushCntQ <= 16'd0;
    end else begin
      if (stallEvt && stallCntQ != 16'hFFFF) stallCntQ <= stallCntQ + 16'd1;
      if (flushEvt && flushCntQ != 16'hFFFF) flushCntQ <= flushCntQ + 16'd1;
    end
  end

  assign stall_cnt = stallCntQ;
  assign flush_cnt = flushCntQ;
`endif

endmodule

// File: tb/tb_pipe_sequencer.sv
// Directed bench for pipe_sequencer with DRAIN_CYCLES=4. It checks the zero-latency control outputs, FSM transitions and reset abort.
// Inputs are driven 1 time unit after the rising edge. Outputs are sampled 1 time unit later, away from the edge.
// The bench builds with or without PIPE_SEQ_PERF_CNT_EN.
module tb_pipe_sequencer;

  logic       clk = 1'b0;
  logic       rst, start, halt_id, jump_id, branch_taken, id_ex_mem_rd, if_id_uses_rt;
  logic [2:0] id_ex_rd, if_id_rs, if_id_rt;
  logic       pc_wr, if_id_wr, if_id_flush, id_ex_flush, busy, done;
  logic [1:0] state;
`ifdef PIPE_SEQ_PERF_CNT_EN
  logic [15:0] stall_cnt, flush_cnt;
`endif

  int testCnt = 0;
  int errCnt  = 0;
  int drainSeen;

  always #5 clk = ~clk;

  pipe_sequencer #(.DRAIN_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .start(start), .halt_id(halt_id), .jump_id(jump_id),
    .branch_taken(branch_taken), .id_ex_mem_rd(id_ex_mem_rd), .id_ex_rd(id_ex_rd),
    .if_id_rs(if_id_rs), .if_id_rt(if_id_rt), .if_id_uses_rt(if_id_uses_rt),
    .pc_wr(pc_wr), .if_id_wr(if_id_wr), .if_id_flush(if_id_flush),
    .id_ex_flush(id_ex_flush), .busy(busy), .done(done),
`ifdef PIPE_SEQ_PERF_CNT_EN
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt),
`endif
    .state(state)
  );

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    testCnt++;
    if (got !== exp) begin
      errCnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge, then settle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clearIn();
    start = 0; halt_id = 0; jump_id = 0; branch_taken = 0; id_ex_mem_rd = 0;
    if_id_uses_rt = 0; id_ex_rd = 3'd0; if_id_rs = 3'd1; if_id_rt = 3'd2;
  endtask

  // Control outputs packed as {pc_wr, if_id_wr, if_id_flush, id_ex_flush}.
  function automatic logic [3:0] ctl();
    return {pc_wr, if_id_wr, if_id_flush, id_ex_flush};
  endfunction

  // Run from reset release into RUN.
  task automatic launch();
    start = 1; #1;
    tick();
    start = 0; #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1; clearIn();
    tick(); tick();
    checkVal("rst_state", state, 2'd0);
    checkVal("rst_ctl", ctl(), 4'b0011);
    checkVal("rst_busy_done", {busy, done}, 2'b00);
`ifdef PIPE_SEQ_PERF_CNT_EN
    checkVal("rst_cnts", {stall_cnt, flush_cnt}, 32'd0);
`endif
    rst = 0;
    tick();
    checkVal("idle_hold", state, 2'd0);

    // Start: still IDLE in the start cycle, then RUN.
    start = 1; #1;
    checkVal("start_cycle_state", state, 2'd0);
    tick();
    start = 0; #1;
    checkVal("run_state", state, 2'd1);
    checkVal("run_ctl", ctl(), 4'b1100);
    checkVal("run_busy_done", {busy, done}, 2'b10);

    // Load-use through rs.
    id_ex_mem_rd = 1; id_ex_rd = 3'd3; if_id_rs = 3'd3; #1;
    checkVal("lu_rs_ctl", ctl(), 4'b0001);
    tick();
    checkVal("lu_rs_state", state, 2'd1);
`ifdef PIPE_SEQ_PERF_CNT_EN
    checkVal("lu_rs_stall_cnt", stall_cnt, 16'd1);
`endif
    clearIn(); #1;
    checkVal("lu_release_ctl", ctl(), 4'b1100);

    // Load-use through rt only counts when rt is read.
    id_ex_mem_rd = 1; id_ex_rd = 3'd5; if_id_rs = 3'd2; if_id_rt = 3'd5; if_id_uses_rt = 0; #1;
    checkVal("lu_rt_unused_ctl", ctl(), 4'b1100);
    if_id_uses_rt = 1; #1;
    checkVal("lu_rt_ctl", ctl(), 4'b0001);
    id_ex_mem_rd = 0; #1;
    checkVal("no_load_match_ctl", ctl(), 4'b1100);
    id_ex_mem_rd = 1; #1;
    tick();
    clearIn(); #1;
`ifdef PIPE_SEQ_PERF_CNT_EN
    checkVal("lu_rt_stall_cnt", stall_cnt, 16'd2);
`endif

    // Branch overrides load-use and halt.
    branch_taken = 1; halt_id = 1; id_ex_mem_rd = 1; id_ex_rd = 3'd4; if_id_rs = 3'd4; #1;
    checkVal("branch_ctl", ctl(), 4'b1111);
    tick();
    clearIn(); #1;
    checkVal("branch_state", state, 2'd1);
`ifdef PIPE_SEQ_PERF_CNT_EN
    checkVal("branch_flush_cnt", flush_cnt, 16'd1);
    checkVal("branch_stall_cnt", stall_cnt, 16'd2);
`endif

    // Jump.
    jump_id = 1; #1;
    checkVal("jump_ctl", ctl(), 4'b1110);
    tick();
    clearIn(); #1;
`ifdef PIPE_SEQ_PERF_CNT_EN
    checkVal("jump_flush_cnt", flush_cnt, 16'd2);
`endif

    // Load-use beats jump.
    jump_id = 1; id_ex_mem_rd = 1; id_ex_rd = 3'd1; if_id_rs = 3'd1; #1;
    checkVal("jump_lu_ctl", ctl(), 4'b0001);
    tick();
    clearIn(); #1;

    // Halt then drain. Branch is held high to show DRAIN ignores it.
    halt_id = 1; #1;
    checkVal("halt_pc_wr", pc_wr, 1'b0);
    checkVal("halt_if_id_flush", if_id_flush, 1'b1);
    tick();
    clearIn(); branch_taken = 1; #1;
    checkVal("drain_state", state, 2'd2);
    checkVal("drain_ctl", ctl(), 4'b0011);
    checkVal("drain_busy", busy, 1'b1);
    drainSeen = 0;
    while (state == 2'd2 && drainSeen < 20) begin
      drainSeen++;
      tick();
    end
    checkVal("drain_len", drainSeen, 4);
    branch_taken = 0; #1;
    checkVal("halted_state", state, 2'd3);
    checkVal("halted_busy_done", {busy, done}, 2'b01);
    checkVal("halted_ctl", ctl(), 4'b0011);
    start = 1; #1;
    tick(); tick();
    start = 0; #1;
    checkVal("halted_ignores_start", state, 2'd3);

    // Reset abort in the 2nd DRAIN cycle.
    rst = 1; #1;
    checkVal("rst_from_halted", state, 2'd0);
    tick();
    rst = 0; #1;
    launch();
    halt_id = 1; #1;
    tick();
    halt_id = 0; #1;
    tick();
    checkVal("second_drain_cycle", state, 2'd2);
    #2 rst = 1; #1;
    checkVal("async_rst_state", state, 2'd0);
    checkVal("async_rst_ctl", ctl(), 4'b0011);
    checkVal("async_rst_busy_done", {busy, done}, 2'b00);
    tick();
    rst = 0; #1;
    tick();
    checkVal("post_rst_idle", state, 2'd0);
    launch();
    checkVal("restart_state", state, 2'd1);
    checkVal("restart_ctl", ctl(), 4'b1100);
`ifdef PIPE_SEQ_PERF_CNT_EN
    checkVal("restart_cnts", {stall_cnt, flush_cnt}, 32'd0);
`endif
    // The drain counter must start fresh: a full 4 cycles again.
    halt_id = 1; #1;
    tick();
    halt_id = 0; #1;
    drainSeen = 0;
    while (state == 2'd2 && drainSeen < 20) begin
      drainSeen++;
      tick();
    end
    checkVal("redrain_len", drainSeen, 4);
    checkVal("redrain_halted", state, 2'd3);

    $display("[TB] %0d tests run, %0d failed", testCnt, errCnt);
    $finish;
  end

endmodule

// File: doc/pipe_sequencer.md
PIPE_SEQUENCER -- requirements
Module: pipe_sequencer

Interface
REQ-001 SHALL have parameter DRAIN_CYCLES, default 4, meaning the number of cycles spent flushing EX/MEM/WB after halt is decoded (legal range 1..15).
REQ-002 SHALL have port clk  input  1  rising-edge clock; the single clock of the block.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port start  input  1  level sampled in IDLE; launches execution.
REQ-005 SHALL have port halt_id  input  1  halt opcode decoded in the ID stage.
REQ-006 SHALL have port jump_id  input  1  jump/call/return decoded in ID; PC redirected from ID.
REQ-007 SHALL have port branch_taken  input  1  conditional branch resolved taken in EX.
REQ-008 SHALL have port id_ex_mem_rd  input  1  instruction in ID/EX is a load (ldm).
REQ-009 SHALL have port id_ex_rd  input  3  destination register of the ID/EX instruction.
REQ-010 SHALL have ports if_id_rs and if_id_rt  input  3 each  source registers of the IF/ID instruction.
REQ-011 SHALL have port if_id_uses_rt  input  1  IF/ID instruction reads rt.
REQ-012 SHALL have ports pc_wr, if_id_wr, if_id_flush, id_ex_flush  output  1 each  pipeline register enables/clears.
REQ-013 SHALL have ports busy and done  output  1 each  status; and state  output  2  current FSM encoding.

Function
REQ-014 SHALL implement FSM IDLE=0, RUN=1, DRAIN=2, HALTED=3, with state output equal to the current encoding.
REQ-015 In IDLE, SHALL drive pc_wr=0, if_id_wr=0, both flushes=1, and SHALL go to RUN on the next edge when start=1.
REQ-016 In RUN, load_use = id_ex_mem_rd & (id_ex_rd==if_id_rs | (if_id_uses_rt & id_ex_rd==if_id_rt)).
REQ-017 In RUN with branch_taken=1, SHALL assert pc_wr=1, if_id_wr=1, if_id_flush=1, id_ex_flush=1, and SHALL ignore load_use, jump_id and halt_id in that cycle.
REQ-018 In RUN with load_use=1 and branch_taken=0, SHALL assert pc_wr=0, if_id_wr=0, id_ex_flush=1 and if_id_flush=0, giving a one-bubble stall with no state change.
REQ-019 In RUN with jump_id=1 and no branch_taken or load_use, SHALL assert pc_wr=1, if_id_wr=1, if_id_flush=1 and id_ex_flush=0.
REQ-020 In RUN with halt_id=1 and no branch_taken or load_use, SHALL assert pc_wr=0, if_id_flush=1, load the drain counter with DRAIN_CYCLES-1, and enter DRAIN.
REQ-021 Otherwise in RUN, SHALL assert pc_wr=1 and if_id_wr=1, with both flushes=0.
REQ-022 In DRAIN, SHALL assert pc_wr=0, if_id_wr=0, if_id_flush=1 and id_ex_flush=1, and decrement the 4-bit counter each cycle; when the counter is 0 it SHALL go to HALTED (DRAIN lasts exactly DRAIN_CYCLES cycles). branch_taken is ignored in DRAIN.
REQ-023 In HALTED, SHALL use the same outputs as IDLE plus done=1; start is ignored, and only rst leaves HALTED.
REQ-024 busy SHALL be 1 in RUN and DRAIN, 0 otherwise; done SHALL be 1 only in HALTED.
REQ-025 All outputs except the counter SHALL be combinational from state and inputs, with zero-cycle latency.

Reset
REQ-026 rst=1 SHALL asynchronously force IDLE, drain counter=0 and performance counters=0; with rst=1 the outputs SHALL be pc_wr=0, if_id_wr=0, flushes=1, busy=0, done=0, state=0.
REQ-027 rst asserted during RUN or DRAIN SHALL abort immediately with no residual effect after release.

Configuration
REQ-028 Macro PIPE_SEQ_PERF_CNT_EN: when defined, SHALL add outputs stall_cnt and flush_cnt (16 bits each, saturating at 0xFFFF). stall_cnt increments on each REQ-018 cycle; flush_cnt increments on each REQ-017 or REQ-019 cycle. When undefined, these ports and registers SHALL be absent.

Verification
REQ-029 Reset, then start=1 for one cycle -> state 0 then 1; pc_wr=1, busy=1.
REQ-030 RUN, id_ex_mem_rd=1, id_ex_rd=3, if_id_rs=3 -> pc_wr=0, if_id_wr=0, id_ex_flush=1 for exactly that cycle; with PERF_CNT_EN, stall_cnt=1.
REQ-031 RUN, branch_taken=1 together with load_use=1 and halt_id=1 -> both flushes=1, pc_wr=1, state stays RUN.
REQ-032 RUN, halt_id=1 with DRAIN_CYCLES=4 -> exactly 4 cycles in DRAIN, then state=3, done=1; a later start=1 leaves state=3.
REQ-033 rst pulsed in the 2nd DRAIN cycle -> state=0 immediately; a later start restarts in RUN and the counters read 0.
REQ-034 RUN, jump_id=1 -> if_id_flush=1, id_ex_flush=0, pc_wr=1; with PERF_CNT_EN, flush_cnt increments by 1.
